// File: rtl/lstm_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_acc_pkg : shared widths and weight-streamer state encoding      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lstm_acc_pkg;

  localparam int unsigned FEATURE_BITS_DEF = 4;
  localparam int unsigned ELEMENT_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/dpr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpr_bank : one weight bank, synchronous write, registered read       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpr_bank #(
  parameter int ADDR_BITS    = 8,
  parameter int ELEMENT_BITS = 8,
  parameter int DEPTH        = 2 ** ADDR_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [ELEMENT_BITS-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [ELEMENT_BITS-1:0] rdata
);

  logic [ELEMENT_BITS-1:0] mem [DEPTH];

  // Storage is deliberately unreset so weights survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register holds its value when re is low; the streamer relies on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/dpr_w_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpr_w_stream : ping-pong weight RAM with direct read and streamer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpr_w_stream
  import lstm_acc_pkg::*;
#(
  parameter int FEATURE_BITS = FEATURE_BITS_DEF,
  parameter int ELEMENT_BITS = ELEMENT_BITS_DEF,
  parameter int ADDR_BITS    = 2 * FEATURE_BITS,
  parameter int DEPTH        = 2 ** ADDR_BITS
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic [FEATURE_BITS-1:0] m,
  input  logic [FEATURE_BITS-1:0] gamma,
  input  logic [ADDR_BITS-1:0]    address_in,
  input  logic [ELEMENT_BITS-1:0] data_in,
  input  logic                    cs_in,
  input  logic                    we_in,
  input  logic                    swap_in,
  input  logic [ADDR_BITS-1:0]    address_out,
  input  logic                    cs_out,
  input  logic                    oe_out,
  input  logic                    start_in,
  input  logic                    ready_in,
  output logic [ELEMENT_BITS-1:0] data_out,
  output logic                    valid_out,
  output logic                    last_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    rd_bank_out,
  output logic                    err_out
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  stream_state_t           state, state_nxt;
  logic                    rd_bank, swap_pend, err;
  logic [ADDR_BITS-1:0]    total, cnt, total_nxt, rd_addr;
  logic                    pv, pl, sv, sl, dr_v, rsel;
  logic [ELEMENT_BITS-1:0] skid, bank_q;
  logic [ELEMENT_BITS-1:0] rdata [2];
  logic                    issue, last_issue, dr_req, rd_en, s_acc;
  logic                    enter_done, apply_swap, busy;

  assign total_nxt  = ADDR_BITS'(m) * ADDR_BITS'(gamma);
  assign busy       = (state != IDLE);
  // Issue only while the output register + skid can absorb the in-flight word.
  assign issue      = (state == STREAM) && !(sv && !ready_in);
  assign last_issue = issue && (cnt == total - ADDR_ONE);
  assign dr_req     = (state == IDLE) && cs_out && oe_out;
  assign rd_en      = issue || dr_req;
  assign rd_addr    = issue ? cnt : address_out;
  assign s_acc      = (pv || sv) && ready_in;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      dpr_bank #(
        .ADDR_BITS   (ADDR_BITS),
        .ELEMENT_BITS(ELEMENT_BITS),
        .DEPTH       (DEPTH)
      ) u_bank (
        .clk  (sys_clk),
        .rst_n(reset_n),
        .we   (cs_in && we_in && (rd_bank != 1'(b))),
        .waddr(address_in),
        .wdata(data_in),
        .re   (rd_en),
        .raddr(rd_addr),
        .rdata(rdata[b])
      );
    end
  endgenerate

  assign bank_q      = rsel ? rdata[1] : rdata[0];
  assign data_out    = sv ? skid : bank_q;
  assign valid_out   = dr_v || pv || sv;
  assign last_out    = sv ? sl : (pv && pl);
  assign rd_bank_out = rd_bank;
  assign err_out     = err;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = (total_nxt == '0) ? DONE : STREAM;
      STREAM:  if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (s_acc && last_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_out = busy;
    done_out = (state == DONE);
  end

  // A deferred swap lands on the edge into DONE so the new bank shows with done_out.
  assign enter_done = (state_nxt == DONE) && (state != DONE);
  assign apply_swap = (swap_in && (state == IDLE || state == DONE)) ||
                      (enter_done && (swap_pend || swap_in));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank   <= 1'b0;
      swap_pend <= 1'b0;
      err       <= 1'b0;
      total     <= '0;
      cnt       <= '0;
      dr_v      <= 1'b0;
      rsel      <= 1'b0;
      pv        <= 1'b0;
      pl        <= 1'b0;
      sv        <= 1'b0;
      sl        <= 1'b0;
      skid      <= '0;
    end else begin
      rd_bank   <= rd_bank ^ apply_swap;
      swap_pend <= apply_swap ? 1'b0 : (swap_pend || (swap_in && busy));
      err       <= err || (busy && cs_out && oe_out);
      dr_v      <= dr_req;
      if (rd_en) rsel <= rd_bank;
      if (state == IDLE && start_in) begin
        total <= total_nxt;
        cnt   <= '0;
      end else if (issue) begin
        cnt <= cnt + ADDR_ONE;
      end
      // Skid holds the older word whenever both entries are occupied.
      if (!sv) begin
        if (pv && !s_acc && issue) begin
          sv   <= 1'b1;
          skid <= bank_q;
          sl   <= pl;
        end
      end else if (s_acc) begin
        if (issue) begin
          skid <= bank_q;
          sl   <= pl;
        end else begin
          sv <= 1'b0;
        end
      end
      if (issue) begin
        pv <= 1'b1;
        pl <= last_issue;
      end else if (s_acc && !sv) begin
        pv <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpr_w_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpr_w_stream : directed scoreboard bench for dpr_w_stream         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dpr_w_stream;

  logic       sys_clk, reset_n;
  logic [3:0] m, gamma;
  logic [7:0] address_in, data_in, address_out;
  logic       cs_in, we_in, swap_in, cs_out, oe_out, start_in, ready_in;
  logic [7:0] data_out;
  logic       valid_out, last_out, busy_out, done_out, rd_bank_out, err_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  int first_c, last_c, done_c, nxf;
  logic rb_done, rb_pre;

  dpr_w_stream dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .m(m), .gamma(gamma),
    .address_in(address_in), .data_in(data_in), .cs_in(cs_in), .we_in(we_in),
    .swap_in(swap_in), .address_out(address_out), .cs_out(cs_out), .oe_out(oe_out),
    .start_in(start_in), .ready_in(ready_in), .data_out(data_out),
    .valid_out(valid_out), .last_out(last_out), .busy_out(busy_out),
    .done_out(done_out), .rd_bank_out(rd_bank_out), .err_out(err_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dread(input logic [7:0] a, input logic [7:0] expv);
    @(negedge sys_clk);
    address_out = a; cs_out = 1'b1; oe_out = 1'b1;
    sb.push_back(expv);
    @(negedge sys_clk);
    cs_out = 1'b0; oe_out = 1'b0;
    chk("dr_valid", valid_out, 1);
    chk("dr_data", data_out, (sb.size() != 0) ? sb.pop_front() : 9'h1FF);
    chk("dr_last", last_out, 0);
    @(negedge sys_clk);
    chk("dr_valid_drop", valid_out, 0);
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0,1 repeating.
  task automatic run_stream(input logic [3:0] mm, input logic [3:0] gg, input int mode,
                            input bit sw, input bit mid, input int rst_at);
    bit r, stall;
    logic [7:0] held;
    logic prev_rb;
    logic [31:0] expv;
    for (int k = 0; k < int'(mm) * int'(gg); k++) sb.push_back(8'(8'h10 + k));
    first_c = -1; last_c = -1; done_c = -1; nxf = 0; stall = 0; held = '0;
    prev_rb = rd_bank_out;
    @(negedge sys_clk);
    m = mm; gamma = gg; start_in = 1'b1; swap_in = sw; ready_in = 1'b1;
    for (int c = 1; c < 300; c++) begin
      @(negedge sys_clk);
      start_in   = 1'b0;
      swap_in    = mid && (c == 5);
      cs_in      = mid && (c == 5);
      we_in      = mid && (c == 5);
      address_in = 8'd3;
      data_in    = 8'hFF;
      if (stall) chk("stall_hold", {valid_out, data_out}, {1'b1, held});
      r = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
      ready_in = r;
      if (valid_out && r) begin
        nxf++;
        if (first_c < 0) first_c = c;
        last_c = c;
        expv = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h1FF;
        chk("stream_data", data_out, expv);
        chk("stream_last", last_out, sb.size() == 0);
      end
      stall = valid_out && !r;
      held  = data_out;
      if (done_out) begin
        done_c = c; rb_done = rd_bank_out; rb_pre = prev_rb;
        break;
      end
      prev_rb = rd_bank_out;
      if (rst_at > 0 && nxf == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("reset_abort_outs",
            {data_out, valid_out, last_out, busy_out, done_out, rd_bank_out, err_out}, 0);
        sb.delete();
        break;
      end
    end
    if (rst_at == 0) chk("done_seen", done_c > 0, 1);
  endtask

  initial begin
    reset_n = 1'b0; m = '0; gamma = '0; address_in = '0; data_in = '0;
    cs_in = 0; we_in = 0; swap_in = 0; address_out = '0; cs_out = 0; oe_out = 0;
    start_in = 0; ready_in = 0;
    repeat (3) @(negedge sys_clk);
    chk("reset_outs",
        {data_out, valid_out, last_out, busy_out, done_out, rd_bank_out, err_out}, 0);
    reset_n = 1'b1;

    // 1: load bank 1, swap, direct read
    for (int a = 0; a < 27; a++) begin
      @(negedge sys_clk);
      cs_in = 1'b1; we_in = 1'b1; address_in = 8'(a); data_in = 8'(a + 16);
    end
    @(negedge sys_clk);
    cs_in = 1'b0; we_in = 1'b0; swap_in = 1'b1;
    @(negedge sys_clk);
    swap_in = 1'b0;
    chk("rd_bank_after_swap", rd_bank_out, 1);
    dread(8'd5, 8'h15);

    // 2: full-rate stream 9x3
    run_stream(4'd9, 4'd3, 0, 1'b0, 1'b0, 0);
    chk("full_first_cycle", first_c, 2);
    chk("full_last_cycle", last_c, 28);
    chk("full_count", nxf, 27);
    chk("full_done_cycle", done_c, 29);
    @(negedge sys_clk);
    chk("full_idle_after", {busy_out, done_out, valid_out}, 0);

    // 3: backpressured stream
    run_stream(4'd9, 4'd3, 1, 1'b0, 1'b0, 0);
    chk("bp_count", nxf, 27);
    chk("bp_sb_empty", sb.size(), 0);

    // 4: mid-stream swap and shadow write
    run_stream(4'd9, 4'd3, 0, 1'b0, 1'b1, 0);
    chk("mid_count", nxf, 27);
    chk("mid_rb_before_done", rb_pre, 1);
    chk("mid_rb_at_done", rb_done, 0);
    dread(8'd3, 8'hFF);

    // 5: empty stream, direct read while busy
    @(negedge sys_clk);
    m = 4'd0; gamma = 4'd3; start_in = 1'b1;
    @(negedge sys_clk);
    start_in = 1'b0;
    chk("empty_done", done_out, 1);
    chk("empty_no_valid", valid_out, 0);
    cs_out = 1'b1; oe_out = 1'b1; address_out = 8'd0;
    @(negedge sys_clk);
    cs_out = 1'b0; oe_out = 1'b0;
    chk("err_set", err_out, 1);
    chk("busy_read_ignored", valid_out, 0);
    chk("empty_back_idle", {busy_out, done_out}, 0);
    repeat (3) @(negedge sys_clk);
    chk("err_sticky", err_out, 1);

    // 6: reset mid-stream, then a fresh stream (start+swap re-selects bank 1)
    run_stream(4'd9, 4'd3, 0, 1'b1, 1'b0, 10);
    chk("abort_count", nxf, 10);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    run_stream(4'd9, 4'd3, 0, 1'b1, 1'b0, 0);
    chk("fresh_count", nxf, 27);
    chk("fresh_done_cycle", done_c, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpr_w_stream.md
Name: dpr_w_stream

Overview:
- Parametrised successor to the single-bank W_i dual-port RAM.
- Two ping-pong weight banks: the host writes the shadow bank while the systolic array reads the active bank.
- Active bank is read either by direct address (legacy mode) or by an autonomous row-major streamer with valid/ready backpressure.
- Sits between the weight loader and the systolic array weight inputs.

Parameters:
- FEATURE_BITS, 4, width of the m/gamma dimension fields.
- ELEMENT_BITS, 8, width of one weight element.
- ADDR_BITS, 2*FEATURE_BITS, address width.
- DEPTH, 2**ADDR_BITS, words per bank.

Ports:
- sys_clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m  in  FEATURE_BITS  columns per row; sampled at stream start.
- gamma  in  FEATURE_BITS  rows; sampled at stream start.
- address_in  in  ADDR_BITS  write address into shadow bank.
- data_in  in  ELEMENT_BITS  write data.
- cs_in  in  1  write chip select.
- we_in  in  1  write enable; a write occurs when cs_in and we_in are both high.
- swap_in  in  1  pulse requesting exchange of active and shadow banks.
- address_out  in  ADDR_BITS  direct-read address.
- cs_out  in  1  direct-read chip select.
- oe_out  in  1  direct-read output enable; a read occurs when cs_out and oe_out are both high.
- start_in  in  1  pulse that starts a stream.
- ready_in  in  1  consumer ready.
- data_out  out  ELEMENT_BITS  read data.
- valid_out  out  1  data_out valid.
- last_out  out  1  final element of the stream; qualified by valid_out.
- busy_out  out  1  streamer not idle.
- done_out  out  1  one-cycle pulse at stream completion.
- rd_bank_out  out  1  index of the active bank.
- err_out  out  1  sticky collision flag.

Behaviour:
Reset:
- All outputs 0; active bank = 0; FSM = IDLE; pending swap cleared.
- Bank contents are not cleared and survive reset.
- Assertion mid-stream aborts the stream immediately.

Writes:
- When cs_in & we_in, data_in is written to shadow bank[address_in] at the clock edge. Always permitted, including mid-stream.

Swap:
- swap_in while IDLE: rd_bank toggles at that edge.
- swap_in while busy: the swap is held pending and applied in the cycle done_out pulses.
- A write in the same cycle as a swap targets the pre-swap shadow bank.
- start_in and swap_in in the same IDLE cycle: the stream reads the newly active bank.

Direct read (IDLE only):
- cs_out & oe_out at cycle t → data_out = active[address_out] and valid_out = 1 at t+1, for one cycle; last_out = 0.
- ready_in is ignored in this mode.
- A direct-read request while busy is ignored and sets err_out, which stays set until reset.

Streamer FSM:
- IDLE:
  - On start_in, latch m and gamma; total = m*gamma (ADDR_BITS wide, never exceeds DEPTH).
  - If total = 0: go to DONE with no data.
  - Otherwise: go to STREAM.
  - start_in while busy is ignored; it does not set err_out.
- STREAM:
  - Issue reads at addresses 0..total-1, row-major: address = row*m + col.
  - One issue per cycle while the 2-entry output buffer (output register + skid) has space after accounting for in-flight data.
  - Read latency 1.
  - After the final issue, go to DRAIN.
- DRAIN: wait until the element carrying last_out is accepted (valid_out & ready_in), then go to DONE.
- DONE: done_out = 1 for one cycle; apply any pending swap; go to IDLE.
- busy_out = 1 in STREAM, DRAIN and DONE.

Streaming handshake:
- Element transfers when valid_out & ready_in.
- data_out is held stable while valid_out & !ready_in.
- With ready_in held high: throughput is 1 element/cycle, the first element appears 2 cycles after start_in, and there are no bubbles.
- No element is lost or duplicated under any ready_in pattern.

Decomposition:
- Shared package lstm_acc_pkg: ELEMENT_BITS and FEATURE_BITS defaults, and the streamer state enum (IDLE, STREAM, DRAIN, DONE).
- One sub-module, dpr_bank: a single dual-port bank with synchronous write and registered 1-cycle read. Instantiated twice.
- Top level owns bank select, the FSM, the skid buffer and the direct-read mux.

Test Plan:
1. Write bank-1 addresses 0..26 with value = addr+0x10; swap_in; direct-read addr 5 → data_out 0x15, valid_out one cycle later; rd_bank_out = 1.
2. m=9, gamma=3, ready_in=1, start_in → 27 consecutive valid cycles, data 0x10..0x2A; last_out only on 0x2A; done_out one cycle later; busy_out returns low.
3. Same stream with ready_in toggling 1,0,0,1 repeating → exactly 27 transfers in order; data_out held stable during stalls.
4. Mid-stream swap_in plus writes of 0xFF to shadow bank → streamed data unchanged; rd_bank_out toggles in the done_out cycle; a subsequent direct read returns 0xFF.
5. m=0, gamma=3, start_in → no valid_out; done_out one cycle after the cycle following start; a direct read during that stream sets err_out, which stays high.
6. reset_n low at element 10 of a stream → all outputs 0 immediately; after release, a fresh stream returns the full 27 elements with bank contents intact.
